// File: rtl/regfile_dump_reader_if.sv
// Bundles the dump reader's control pins, RegisterFile read ports and beat stream.
// The master modport is the dump reader. The slave modport is the RegisterFile, consumer and controller side.
interface regfile_dump_reader_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              Start;
  logic              Busy;
  logic              Done;
  logic [ADDR_W-1:0] RA;
  logic [ADDR_W-1:0] RB;
  logic [DATA_W-1:0] BusA;
  logic [DATA_W-1:0] BusB;
  logic              OutValid;
  logic              OutReady;
  logic [ADDR_W-1:0] OutIdx;
  logic [DATA_W-1:0] OutData;

  modport master (
    input  Start, BusA, BusB, OutReady,
    output Busy, Done, RA, RB, OutValid, OutIdx, OutData
  );

  modport slave (
    output Start, BusA, BusB, OutReady,
    input  Busy, Done, RA, RB, OutValid, OutIdx, OutData
  );
endinterface

// File: rtl/regfile_dump_reader.sv
// Streams every RegisterFile entry out as (index, value) beats. Each pass reads an even/odd pair and costs 3 cycles when OutReady is held high.
// OutReady low freezes the beat and the FSM. Values are snapshotted per pair, so later writes do not alter a stalled beat.
module regfile_dump_reader #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic                  Clk,
  input  logic                  Reset,
  regfile_dump_reader_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    SEND_A,
    SEND_B,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_PAIR = ADDR_W'(NUM_REGS / 2 - 1);
  localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(2);

  state_t            state;
  logic [ADDR_W-1:0] pair;
  logic [DATA_W-1:0] capB;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state        <= IDLE;
      pair         <= '0;
      capB         <= '0;
      bus.RA       <= '0;
      bus.RB       <= '0;
      bus.OutValid <= 1'b0;
      bus.OutIdx   <= '0;
      bus.OutData  <= '0;
      bus.Busy     <= 1'b0;
      bus.Done     <= 1'b0;
    end else begin
      bus.Done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.Start) begin
            state    <= READ;
            bus.RA   <= '0;
            bus.RB   <= ADDR_W'(1);
            pair     <= '0;
            bus.Busy <= 1'b1;
          end
        end
        READ: begin
          // Port A's value goes straight to the beat; port B's waits in capB for the second beat.
          capB         <= bus.BusB;
          bus.OutValid <= 1'b1;
          bus.OutIdx   <= bus.RA;
          bus.OutData  <= bus.BusA;
          state        <= SEND_A;
        end
        SEND_A: begin
          if (bus.OutReady) begin
            bus.OutIdx  <= bus.RB;
            bus.OutData <= capB;
            state       <= SEND_B;
          end
        end
        SEND_B: begin
          if (bus.OutReady) begin
            bus.OutValid <= 1'b0;
            if (pair == LAST_PAIR) begin
              state    <= DONE;
              bus.Done <= 1'b1;
            end else begin
              pair   <= pair + ADDR_W'(1);
              bus.RA <= bus.RA + STEP;
              bus.RB <= bus.RB + STEP;
              state  <= READ;
            end
          end
        end
        DONE: begin
          bus.Busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
